// File: rtl/mem_access_sched_pkg.sv
// rtl/mem_access_sched_pkg.sv - shared constants, FSM encoding and time helper for the access scheduler
//
// Package mem_sched_pkg
//   SIZE_ADDR, SIZE_COUNT, FIFO_DEPTH, FIFO_DEPTH_LOG : widths and depths
//   sched_state_t                                     : scheduler FSM encoding
//   time_reached(now, due)                            : wrap-safe "now >= due" test
package mem_sched_pkg;

  localparam int SIZE_ADDR      = 32;
  localparam int SIZE_COUNT     = 16;
  localparam int FIFO_DEPTH     = 32;
  localparam int FIFO_DEPTH_LOG = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    HOLD   = 2'd3
  } sched_state_t;

  // Valid while the two times are less than half the counter range apart,
  // which is why release delays must stay below 2^(SIZE_COUNT-1).
  function automatic logic time_reached(input logic [SIZE_COUNT-1:0] now,
                                        input logic [SIZE_COUNT-1:0] due_time);
    logic [SIZE_COUNT-1:0] diff;
    diff = now - due_time;
    return ~diff[SIZE_COUNT-1];
  endfunction

endpackage

// File: rtl/mem_access_sched_rr_arbiter.sv
// rtl/mem_access_sched_rr_arbiter.sv - combinational round-robin arbiter
//
// Module rr_arbiter
//   req   : per-lane request vector
//   ptr   : lane with highest priority this cycle
//   grant : one-hot grant of the first requesting lane at or after ptr
//   idx   : binary index of the granted lane
//   any   : at least one lane requested
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int lane;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    lane  = 0;
    // Walk the lanes starting at ptr and stop at the first requester.
    for (int i = 0; i < NUM_REQ; i++) begin
      lane = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[lane]) begin
        any         = 1'b1;
        idx         = IDX_W'(lane);
        grant[lane] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_sched.sv
// rtl/mem_access_sched.sv - schedules lane RAM accesses through the timestamped access FIFO
//
// Module mem_access_sched
//   clk, reset           : clock, asynchronous active-high reset
//   stall_i, flush_i     : global freeze; level request to stop accepting and drain
//   cfg_delay            : release delay, consumed by the FIFO on push
//   req_*                : lane requests (packed, lane 0 in the LSBs); req_grant is the accept strobe
//   fifo_push/ram_addr/addr/count : FIFO write side, count is the free-running time base
//   fifo_full, fifo_head_*: FIFO status and head entry
//   fifo_pop             : FIFO read strobe
//   rel_*                : registered released access and its residency time
//   occupancy            : entries held in the FIFO
//   flush_done           : one-cycle pulse when a drain empties the FIFO
module mem_access_sched
  import mem_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SIZE_RAM_LOG = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic [9:0]                    cfg_delay,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*SIZE_RAM_LOG-1:0] req_ram_addr,
  input  logic [NUM_REQ*SIZE_ADDR-1:0]  req_addr,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic                          fifo_push,
  output logic [SIZE_RAM_LOG-1:0]       fifo_ram_addr,
  output logic [SIZE_ADDR-1:0]          fifo_addr,
  output logic [SIZE_COUNT-1:0]         fifo_count,
  input  logic                          fifo_full,
  input  logic [SIZE_COUNT-1:0]         fifo_head_out_time,
  input  logic [SIZE_COUNT-1:0]         fifo_head_in_time,
  input  logic [SIZE_RAM_LOG-1:0]       fifo_head_ram_addr,
  input  logic [SIZE_ADDR-1:0]          fifo_head_addr,
  output logic                          fifo_pop,
  output logic                          rel_valid,
  output logic [SIZE_RAM_LOG-1:0]       rel_ram_addr,
  output logic [SIZE_ADDR-1:0]          rel_addr,
  output logic [SIZE_COUNT-1:0]         rel_wait,
  output logic [FIFO_DEPTH_LOG:0]       occupancy,
  output logic                          flush_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [FIFO_DEPTH_LOG:0] OCC_LIMIT = (FIFO_DEPTH_LOG+1)'(FIFO_DEPTH - 1);

  sched_state_t           state, state_next;
  logic [SIZE_COUNT-1:0]  count;
  logic [FIFO_DEPTH_LOG:0] occ, occ_next;
  logic [IDX_W-1:0]       rr_ptr, ptr_next;
  logic [NUM_REQ-1:0]     arb_grant;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   arb_any;
  logic                   accept_en;
  logic                   push_ok;
  logic                   due;

  // The delay only matters to the FIFO, which samples it on push.
  logic cfg_delay_unused;
  assign cfg_delay_unused = ^cfg_delay;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (gnt_idx),
    .any   (arb_any)
  );

  // A raised flush stops intake at once, even before the FSM reaches DRAIN.
  assign push_ok   = ~stall_i & ~fifo_full & (occ < OCC_LIMIT) & accept_en & ~flush_i;
  assign req_grant = arb_grant & {NUM_REQ{push_ok}};
  assign fifo_push = push_ok & arb_any;

  assign fifo_ram_addr = req_ram_addr[gnt_idx*SIZE_RAM_LOG +: SIZE_RAM_LOG];
  assign fifo_addr     = req_addr[gnt_idx*SIZE_ADDR +: SIZE_ADDR];
  assign fifo_count    = count;

  // occ gates the head check so stale head data of an empty FIFO is ignored.
  assign due      = (occ != '0) && time_reached(count, fifo_head_out_time);
  assign fifo_pop = due & ~stall_i;

  assign occ_next  = occ + {{FIFO_DEPTH_LOG{1'b0}}, fifo_push} - {{FIFO_DEPTH_LOG{1'b0}}, fifo_pop};
  assign ptr_next  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign occupancy = occ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (!stall_i) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (flush_i) state_next = DRAIN;
               else if (fifo_push) state_next = ACTIVE;
      ACTIVE:  if (flush_i) state_next = DRAIN;
               else if (occ_next == '0) state_next = IDLE;
      DRAIN:   if (occ_next == '0) state_next = flush_i ? HOLD : IDLE;
      HOLD:    if (!flush_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept_en  = (state == IDLE) || (state == ACTIVE);
    flush_done = (state == DRAIN) && (occ_next == '0) && ~stall_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      occ          <= '0;
      rr_ptr       <= '0;
      rel_valid    <= 1'b0;
      rel_ram_addr <= '0;
      rel_addr     <= '0;
      rel_wait     <= '0;
    end else if (!stall_i) begin
      count     <= count + 1'b1;
      occ       <= occ_next;
      rel_valid <= fifo_pop;
      if (fifo_push) begin
        rr_ptr <= ptr_next;
      end
      if (fifo_pop) begin
        rel_ram_addr <= fifo_head_ram_addr;
        rel_addr     <= fifo_head_addr;
        rel_wait     <= count - fifo_head_in_time;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sched.sv
// tb/tb_mem_access_sched.sv - directed self-checking bench for mem_access_sched
module tb_mem_access_sched;

  localparam int NR = 4;
  localparam int RL = 5;
  localparam int AW = 32;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            tb_full = 1'b0;
  logic [9:0]      cfg_delay = '0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*RL-1:0] req_ram_addr;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   req_grant;
  logic            fifo_push, fifo_pop, rel_valid, flush_done;
  logic [RL-1:0]   fifo_ram_addr, rel_ram_addr, head_ram;
  logic [AW-1:0]   fifo_addr, rel_addr, head_addr;
  logic [CW-1:0]   fifo_count, rel_wait, head_in, head_out;
  logic [5:0]      occupancy;

  always #5 clk = ~clk;

  mem_access_sched dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .cfg_delay(cfg_delay),
    .req_valid(req_valid), .req_ram_addr(req_ram_addr), .req_addr(req_addr), .req_grant(req_grant),
    .fifo_push(fifo_push), .fifo_ram_addr(fifo_ram_addr), .fifo_addr(fifo_addr), .fifo_count(fifo_count),
    .fifo_full(tb_full), .fifo_head_out_time(head_out), .fifo_head_in_time(head_in),
    .fifo_head_ram_addr(head_ram), .fifo_head_addr(head_addr), .fifo_pop(fifo_pop),
    .rel_valid(rel_valid), .rel_ram_addr(rel_ram_addr), .rel_addr(rel_addr), .rel_wait(rel_wait),
    .occupancy(occupancy), .flush_done(flush_done)
  );

  // Timestamped FIFO stand-in: synchronous write, head visible from the next cycle.
  logic [RL-1:0] m_ram [32];
  logic [AW-1:0] m_addr [32];
  logic [CW-1:0] m_in [32];
  logic [CW-1:0] m_out [32];
  logic [4:0]    m_wr, m_rd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wr <= '0;
      m_rd <= '0;
    end else begin
      if (fifo_push) begin
        m_ram[m_wr]  <= fifo_ram_addr;
        m_addr[m_wr] <= fifo_addr;
        m_in[m_wr]   <= fifo_count;
        m_out[m_wr]  <= fifo_count + {6'd0, cfg_delay};
        m_wr         <= m_wr + 5'd1;
      end
      if (fifo_pop) m_rd <= m_rd + 5'd1;
    end
  end

  assign head_ram  = m_ram[m_rd];
  assign head_addr = m_addr[m_rd];
  assign head_in   = m_in[m_rd];
  assign head_out  = m_out[m_rd];

  always @(posedge clk) begin
    if (!reset && fifo_push)
      assert ({6'd0, cfg_delay} < 16'h8000) else $error("illegal release delay %0d", cfg_delay);
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [CW-1:0] exp_cnt;
  logic [CW-1:0] c0, c1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns just after the falling edge.
  task automatic step();
    @(posedge clk);
    if (!stall_i && !reset) exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    flush_i   = 1'b0;
    stall_i   = 1'b0;
    tb_full   = 1'b0;
    reset     = 1'b1;
    #2;
    reset     = 1'b0;
    exp_cnt   = '0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      req_ram_addr[i*RL +: RL] = RL'(5'h10 + i);
      req_addr[i*AW +: AW]     = 32'hA000_0000 + i;
    end
    exp_cnt = '0;
    do_reset();

    // Reset state
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_occ", occupancy, 0);
    check("rst_rel_valid", rel_valid, 0);
    check("rst_rel_wait", rel_wait, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_grant", req_grant, 0);

    // Lane 1, delay 3, push at count 10, stall while due at 13
    repeat (10) step();
    req_valid = 4'b0010;
    cfg_delay = 10'd3;
    #1;
    check("t1_count", fifo_count, 10);
    check("t1_grant", req_grant, 4'b0010);
    check("t1_push", fifo_push, 1);
    check("t1_ram", fifo_ram_addr, 5'h11);
    check("t1_addr", fifo_addr, 32'hA000_0001);
    step();
    req_valid = '0;
    #1;
    check("t1_occ1", occupancy, 1);
    check("t1_nopop11", fifo_pop, 0);
    step();
    step();
    stall_i = 1'b1;
    #1;
    check("t1_stall_pop", fifo_pop, 0);
    step();
    stall_i = 1'b0;
    #1;
    check("t1_stall_count", fifo_count, 13);
    check("t1_pop13", fifo_pop, 1);
    step();
    #1;
    check("t1_rel_valid", rel_valid, 1);
    check("t1_rel_wait", rel_wait, 3);
    check("t1_rel_ram", rel_ram_addr, 5'h11);
    check("t1_rel_addr", rel_addr, 32'hA000_0001);
    check("t1_occ0", occupancy, 0);

    // All lanes, delay 0: rr_ptr is 2 after the lane 1 grant
    step();
    cfg_delay = 10'd0;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 6) check("t2_grant", req_grant, 4'b0001 << ((2 + k) % 4));
      if (k == 1) check("t2_norel", rel_valid, 0);
      if (k >= 2) begin
        check("t2_rel_valid", rel_valid, 1);
        check("t2_rel_addr", rel_addr, 32'hA000_0000 + (k % 4));
        check("t2_rel_ram", rel_ram_addr, 5'h10 + (k % 4));
        check("t2_rel_wait", rel_wait, 1);
      end
      if (k == 6) check("t2_occ_k6", occupancy, 1);
      if (k == 7) check("t2_occ_k7", occupancy, 0);
      step();
    end

    // Fill with delay 200
    req_valid = 4'b0001;
    cfg_delay = 10'd200;
    tb_full   = 1'b1;
    #1;
    check("t3_full_grant", req_grant, 0);
    step();
    tb_full = 1'b0;
    c0 = exp_cnt;
    for (int k = 0; k < 31; k++) begin
      #1;
      check("t3_fill_grant", req_grant, 4'b0001);
      step();
    end
    #1;
    check("t3_occ31", occupancy, 31);
    check("t3_sat_grant", req_grant, 0);
    for (int g = 0; g < 300 && exp_cnt != c0 + 16'd200; g++) step();
    #1;
    check("t3_reach", fifo_count, c0 + 16'd200);
    check("t3_pop", fifo_pop, 1);
    check("t3_pop_grant", req_grant, 0);
    step();
    #1;
    check("t3_regrant", req_grant, 4'b0001);
    check("t3_rel_wait", rel_wait, 200);
    req_valid = '0;

    // Time counter wrap
    do_reset();
    for (int g = 0; g < 70000 && exp_cnt != 16'hFFFE; g++) step();
    req_valid = 4'b0001;
    cfg_delay = 10'd5;
    #1;
    check("t4_reach", fifo_count, 16'hFFFE);
    check("t4_grant", req_grant, 4'b0001);
    step();
    req_valid = '0;
    #1;
    check("t4_nopop_ffff", fifo_pop, 0);
    step();
    #1;
    check("t4_count_wrap", fifo_count, 0);
    check("t4_nopop_0000", fifo_pop, 0);
    step();
    step();
    #1;
    check("t4_nopop_0002", fifo_pop, 0);
    step();
    #1;
    check("t4_pop_0003", fifo_pop, 1);
    step();
    #1;
    check("t4_rel_valid", rel_valid, 1);
    check("t4_rel_wait", rel_wait, 5);

    // Flush with 8 entries queued at delay 20
    step();
    req_valid = 4'b0001;
    cfg_delay = 10'd20;
    c1 = exp_cnt;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t5_fill_grant", req_grant, 4'b0001);
      step();
    end
    flush_i = 1'b1;
    #1;
    check("t5_flush_grant", req_grant, 0);
    check("t5_flush_push", fifo_push, 0);
    check("t5_occ8", occupancy, 8);
    for (int g = 0; g < 40 && exp_cnt != c1 + 16'd19; g++) step();
    #1;
    check("t5_nopop_early", fifo_pop, 0);
    step();
    #1;
    check("t5_pop_due", fifo_pop, 1);
    check("t5_drain_grant", req_grant, 0);
    for (int g = 0; g < 40 && exp_cnt != c1 + 16'd26; g++) step();
    #1;
    check("t5_done_early", flush_done, 0);
    step();
    #1;
    check("t5_last_pop", fifo_pop, 1);
    check("t5_done", flush_done, 1);
    step();
    #1;
    check("t5_done_once", flush_done, 0);
    check("t5_hold_grant", req_grant, 0);
    check("t5_occ0", occupancy, 0);
    flush_i = 1'b0;
    #1;
    check("t5_hold_grant2", req_grant, 0);
    step();
    #1;
    check("t5_idle_grant", req_grant, 4'b0001);
    req_valid = '0;

    // Flush on an empty FIFO
    do_reset();
    step();
    flush_i = 1'b1;
    #1;
    check("t5e_done_idle", flush_done, 0);
    step();
    #1;
    check("t5e_done", flush_done, 1);
    flush_i = 1'b0;
    step();
    #1;
    check("t5e_done_after", flush_done, 0);

    // Asynchronous reset mid-stream with five entries queued via lane 2
    req_valid = 4'b0100;
    cfg_delay = 10'd20;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t6_grant", req_grant, 4'b0100);
      step();
    end
    req_valid = '0;
    #1;
    check("t6_occ5", occupancy, 5);
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_occ", occupancy, 0);
    check("t6_async_count", fifo_count, 0);
    check("t6_async_pop", fifo_pop, 0);
    check("t6_async_rel", rel_valid, 0);
    #1;
    reset   = 1'b0;
    exp_cnt = '0;
    step();
    #1;
    check("t6_count1", fifo_count, 1);
    check("t6_nopop", fifo_pop, 0);
    req_valid = 4'b1111;
    #1;
    check("t6_ptr0_grant", req_grant, 4'b0001);
    step();
    req_valid = '0;
    #1;
    check("t6_nopop2", fifo_pop, 0);
    check("t6_occ1", occupancy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
